// File: rtl/vmask_cmp_accum.sv
// vmask_cmp_accum: pipelined vector mask-compare with mask-word accumulation.
// Stage S1 registers per-element compare bits; stage S2 packs them into a
// DATA_WIDTH-bit word at bit pointer P and loads the output register when the
// word fills or the vector op ends. Full valid/ready backpressure.
// Optional feature macro: VMASK_CMP_MASKED_EN (adds in_vm / in_v0 masking).
module vmask_cmp_accum #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int OPSEL_WIDTH = 3,
  parameter int BE_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_vec0,
  input  logic [DATA_WIDTH-1:0]  in_vec1,
  input  logic [1:0]             in_sew,
  input  logic [OPSEL_WIDTH-1:0] in_opSel,
  input  logic [ADDR_WIDTH-1:0]  in_addr,
  input  logic                   in_last,
`ifdef VMASK_CMP_MASKED_EN
  input  logic                   in_vm,
  input  logic [DATA_WIDTH/8-1:0] in_v0,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_vec,
  output logic [BE_WIDTH-1:0]    out_be,
  output logic [ADDR_WIDTH-1:0]  out_addr
);

  // Most elements per beat (SEW=8); width of every per-beat bit vector.
  localparam int EMAX = DATA_WIDTH / 8;
  // Bit pointer must hold P+E up to 2*DATA_WIDTH-1.
  localparam int PW   = $clog2(DATA_WIDTH) + 1;

  // Maps one op code onto the three primitive relations of an element pair.
  function automatic logic cmp_op(input logic [OPSEL_WIDTH-1:0] op,
                                  input logic eq, input logic ltu, input logic lts);
    logic r;
    case (op)
      0:       r = eq;
      1:       r = ~eq;
      2:       r = ltu;
      3:       r = lts;
      4:       r = ltu | eq;
      5:       r = lts | eq;
      6:       r = ~(ltu | eq);
      7:       r = ~(lts | eq);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic                  stall;
  logic [EMAX-1:0]       cmp_bits;

  logic                  s1_valid_reg;
  logic [EMAX-1:0]       s1_bits_reg;
  logic [1:0]            s1_sew_reg;
  logic                  s1_last_reg;
  logic [ADDR_WIDTH-1:0] s1_addr_reg;

  logic [DATA_WIDTH-1:0] acc_reg;
  logic [PW-1:0]         ptr_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;

  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_vec_reg;
  logic [BE_WIDTH-1:0]   out_be_reg;
  logic [ADDR_WIDTH-1:0] out_addr_reg;

  logic [PW-1:0]         elems_s1;
  logic [PW-1:0]         end_ptr;
  logic [DATA_WIDTH-1:0] merged_next;
  logic [BE_WIDTH-1:0]   be_next;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  word_done;

  assign stall     = out_valid_reg & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_valid_reg;
  assign out_vec   = out_vec_reg;
  assign out_be    = out_be_reg;
  assign out_addr  = out_addr_reg;

  // One compare lane set per element width; unused upper bits stay zero.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sew
    localparam int W = 8 << gi;
    localparam int N = DATA_WIDTH / W;
    logic [EMAX-1:0] bits;

    // Per-element eq / unsigned-lt / signed-lt on the full W-bit slice.
    always_comb begin
      bits = '0;
      for (int i = 0; i < N; i++) begin
        bits[i] = cmp_op(in_opSel,
                         in_vec0[i*W +: W] == in_vec1[i*W +: W],
                         in_vec0[i*W +: W] <  in_vec1[i*W +: W],
                         $signed(in_vec0[i*W +: W]) < $signed(in_vec1[i*W +: W]));
`ifdef VMASK_CMP_MASKED_EN
        // Masked-off elements are written as ones (mask-agnostic).
        if (!in_vm && !in_v0[i]) bits[i] = 1'b1;
`endif
      end
    end
  end

  // Pick the lane set matching the beat's element width.
  always_comb begin
    case (in_sew)
      2'd0:    cmp_bits = g_sew[0].bits;
      2'd1:    cmp_bits = g_sew[1].bits;
      2'd2:    cmp_bits = g_sew[2].bits;
      default: cmp_bits = g_sew[3].bits;
    endcase
  end

  // Merge the S1 beat at the bit pointer and decide whether the word closes.
  always_comb begin
    elems_s1    = PW'(DATA_WIDTH >> (3 + s1_sew_reg));
    end_ptr     = ptr_reg + elems_s1;
    merged_next = acc_reg | (DATA_WIDTH'(s1_bits_reg) << ptr_reg);
    // An empty word (P=0) takes its address from the beat that opens it.
    word_addr   = (ptr_reg == '0) ? s1_addr_reg : addr_reg;
    word_done   = s1_valid_reg & ((end_ptr == PW'(DATA_WIDTH)) | s1_last_reg);
    // Words always fill from bit 0, so written bytes are those below end_ptr.
    for (int k = 0; k < BE_WIDTH; k++)
      be_next[k] = end_ptr > PW'(8 * k);
  end

  // S1: register compare bits and beat sideband; frozen while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_bits_reg  <= '0;
      s1_sew_reg   <= '0;
      s1_last_reg  <= 1'b0;
      s1_addr_reg  <= '0;
    end else if (!stall) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_bits_reg <= cmp_bits;
        s1_sew_reg  <= in_sew;
        s1_last_reg <= in_last;
        s1_addr_reg <= in_addr;
      end
    end
  end

  // S2: accumulate, and load the output register when a word completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= '0;
      ptr_reg       <= '0;
      addr_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_vec_reg   <= '0;
      out_be_reg    <= '0;
      out_addr_reg  <= '0;
    end else if (!stall) begin
      // Not stalled, so a presented word is being consumed this edge.
      out_valid_reg <= 1'b0;
      if (word_done) begin
        out_valid_reg <= 1'b1;
        out_vec_reg   <= merged_next;
        out_be_reg    <= be_next;
        out_addr_reg  <= word_addr;
        acc_reg       <= '0;
        ptr_reg       <= '0;
      end else if (s1_valid_reg) begin
        acc_reg  <= merged_next;
        ptr_reg  <= end_ptr;
        addr_reg <= word_addr;
      end
    end
  end

endmodule

// File: tb/tb_vmask_cmp_accum.sv
// Scoreboard testbench for vmask_cmp_accum: directed beats push expected
// words into a queue; a monitor pops and compares on every accepted word.
module tb_vmask_cmp_accum;

  localparam int DW = 64;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_vec0 = '0;
  logic [DW-1:0] in_vec1 = '0;
  logic [1:0]    in_sew = '0;
  logic [2:0]    in_opSel = '0;
  logic [AW-1:0] in_addr = '0;
  logic          in_last = 1'b0;
`ifdef VMASK_CMP_MASKED_EN
  logic          in_vm = 1'b1;
  logic [DW/8-1:0] in_v0 = '0;
`endif
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_vec;
  logic [DW/8-1:0] out_be;
  logic [AW-1:0] out_addr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0]   vec;
    logic [DW/8-1:0] be;
    logic [AW-1:0]   addr;
  } word_t;
  word_t exp_q[$];

  vmask_cmp_accum #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPSEL_WIDTH(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vec0(in_vec0), .in_vec1(in_vec1), .in_sew(in_sew),
    .in_opSel(in_opSel), .in_addr(in_addr), .in_last(in_last),
`ifdef VMASK_CMP_MASKED_EN
    .in_vm(in_vm), .in_v0(in_v0),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .out_be(out_be), .out_addr(out_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every word handed over is compared with the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got vec=%h be=%h addr=%h, none expected", out_vec, out_be, out_addr);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        chk("out_vec", out_vec, e.vec);
        chk("out_be", DW'(out_be), DW'(e.be));
        chk("out_addr", DW'(out_addr), DW'(e.addr));
        $display("word: vec=%h be=%h addr=%h", out_vec, out_be, out_addr);
      end
    end
  end

  task automatic expect_word(input logic [DW-1:0] v, input logic [DW/8-1:0] b, input logic [AW-1:0] a);
    word_t e;
    e.vec = v; e.be = b; e.addr = a;
    exp_q.push_back(e);
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] sew,
                      input logic [2:0] op, input logic [AW-1:0] addr, input logic last);
    int n;
    logic ok;
    in_vec0 = a; in_vec1 = b; in_sew = sew; in_opSel = op; in_addr = addr; in_last = last;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL beat_accept: got in_ready=0 for 50 cycles, required acceptance");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_empty", DW'(exp_q.size()), '0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_out_vec", out_vec, '0);
    chk("rst_out_be", DW'(out_be), '0);
    chk("rst_out_addr", DW'(out_addr), '0);
    chk("rst_in_ready", DW'(in_ready), 64'd1);
    @(posedge clk); #1;

    // SEW=8 eq, 8 equal beats, last on 8 -> full word, latency T+2
    expect_word(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 32'h1000);
    for (int i = 0; i < 8; i++)
      send(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 2'd0, 3'd0, 32'h1000 + 32'(8 * i), i == 7);
    @(negedge clk);
    chk("latency_t1_valid", DW'(out_valid), '0);
    @(negedge clk);
    chk("latency_t2_valid", DW'(out_valid), 64'd1);
    drain();

    // SEW=64 signed lt: -1 < 1 true; unsigned: false
    expect_word(64'd1, 8'h01, 32'h2000);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'd3, 3'd3, 32'h2000, 1'b1);
    expect_word(64'd0, 8'h01, 32'h2100);
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'd3, 3'd2, 32'h2100, 1'b1);
    drain();

    // SEW=32 gtu: elem0 5>1, elem1 2>7 -> 01 per beat, 3 beats
    expect_word(64'b010101, 8'h01, 32'h2200);
    for (int i = 0; i < 3; i++)
      send(64'h0000_0002_0000_0005, 64'h0000_0007_0000_0001, 2'd2, 3'd6, 32'h2200 + 32'(i), i == 2);
    drain();

    // SEW=16 signed gt: {-1,7FFF,1,-32768} vs 0 then vs -1 -> 0110 each
    expect_word(64'h66, 8'h01, 32'h2300);
    send(64'hFFFF_7FFF_0001_8000, 64'h0, 2'd1, 3'd7, 32'h2300, 1'b0);
    send(64'hFFFF_7FFF_0001_8000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 3'd7, 32'h2310, 1'b1);
    drain();

    // Full word without last, then new word opened by a single last beat
    expect_word(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 32'h6000);
    expect_word(64'd1, 8'h01, 32'h7000);
    for (int i = 0; i < 8; i++)
      send(64'hAAAA_5555_0000_FFFF, 64'hAAAA_5555_0000_FFFF, 2'd0, 3'd0, 32'h6000 + 32'(i), 1'b0);
    send(64'd9, 64'd9, 2'd3, 3'd0, 32'h7000, 1'b1);
    drain();

    // Backpressure: two words pending, consumer stalled 5 cycles
    out_ready = 1'b0;
    expect_word(64'd1, 8'h01, 32'h3000);
    expect_word(64'd0, 8'h01, 32'h3100);
    send(64'd4, 64'd4, 2'd3, 3'd0, 32'h3000, 1'b1);
    send(64'd4, 64'd4, 2'd3, 3'd1, 32'h3100, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", DW'(in_ready), '0);
      chk("stall_out_valid", DW'(out_valid), 64'd1);
      chk("stall_out_vec", out_vec, 64'd1);
      chk("stall_out_addr", DW'(out_addr), 64'h3000);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

    // Reset mid-operation discards 3 beats; fresh op starts at bit 0
    for (int i = 0; i < 3; i++)
      send(64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444, 2'd0, 3'd0, 32'h4000, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", DW'(out_valid), '0);
    chk("midrst_in_ready", DW'(in_ready), 64'd1);
    @(posedge clk); #1;
    // leu per byte: 08..05 <= 04 false, 04..01 true -> F0 per beat
    expect_word(64'hF0F0_F0F0_F0F0_F0F0, 8'hFF, 32'h5000);
    for (int i = 0; i < 8; i++)
      send(64'h0102_0304_0506_0708, 64'h0404_0404_0404_0404, 2'd0, 3'd4, 32'h5000 + 32'(i), i == 7);
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vmask_cmp_accum.md
Name: vmask_cmp_accum

Overview:
- Pipelined, parametrised vector mask-compare unit for the vALU.
- Compares two element vectors per beat at SEW 8/16/32/64 and produces one mask bit per element.
- Packs those bits across consecutive beats into a DATA_WIDTH-bit mask accumulator. Emits a full mask word, or a partial word on the last beat, with byte enables and address.
- Adds valid/ready backpressure and correct two's-complement signed compares.

Parameters:
- DATA_WIDTH, 64: element data width and mask word width; power of two, >=64.
- ADDR_WIDTH, 32: destination address width.
- OPSEL_WIDTH, 3: compare op select width.
- BE_WIDTH, DATA_WIDTH/8: byte enable width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_vec0  in  DATA_WIDTH  operand A (vs2)
- in_vec1  in  DATA_WIDTH  operand B (vs1/scalar splat)
- in_sew  in  2  0=8b, 1=16b, 2=32b, 3=64b; constant from first beat through in_last
- in_opSel  in  OPSEL_WIDTH  compare op
- in_addr  in  ADDR_WIDTH  destination address, sampled on first beat of each word
- in_last  in  1  final beat of the vector op
- out_valid  out  1  mask word valid
- out_ready  in  1  consumer accepts word
- out_vec  out  DATA_WIDTH  packed mask word
- out_be  out  BE_WIDTH  bytes of out_vec holding written bits
- out_addr  out  ADDR_WIDTH  address of word

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, including out_valid, out_vec, out_be and out_addr. Accumulator, bit pointer and pipeline valids are cleared. in_ready=1 in the cycle after reset.
- Reset mid-operation discards all in-flight beats and any partial word.
- Elements per beat: E = DATA_WIDTH >> (3+in_sew). Element i occupies bits [(i+1)*W-1 : i*W], W = 8<<sew.
- opSel encoding:
  - 0 eq, 1 ne
  - 2 ltu, 3 lt (signed)
  - 4 leu, 5 le (signed)
  - 6 gtu, 7 gt (signed)
- Signed compares are true two's complement on full W bits.
- Stage S1 registers E result bits (LSB = element 0) plus sew, last and addr.
- Stage S2 ORs the S1 bits into the accumulator at bit pointer P, then sets P += E.
- Output load:
  - When P+E == DATA_WIDTH, or the S1 beat has last=1, the merged word loads the output register.
  - out_be byte k = 1 iff any bit in [8k+7:8k] was written for this word.
  - The accumulator and P then clear; the next beat starts a new word.
- Address: out_addr = in_addr of the word's first beat. Subsequent beats' in_addr are ignored for that word.
- Latency: a beat accepted at cycle T that completes a word gives out_valid=1 at T+2.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - While stall=1, all stages hold their contents.
  - out_* are stable while out_valid=1 and out_ready=0.
  - When out_valid=1 and out_ready=1, the word is consumed. A new word may load in the same cycle, giving back-to-back 1/cycle throughput.
- Invalid beats (in_valid=0) do not advance P or the accumulator.
- Bits beyond P in a partial word are 0.
- A single-beat vector with in_last=1 emits a partial word.
- When DATA_WIDTH/E beats fill the word exactly and the last of them has in_last=1, exactly one word is emitted, never an extra empty one.

Optional Feature:
- Macro: VMASK_CMP_MASKED_EN.
- When defined:
  - Adds ports in_vm (1) and in_v0 (DATA_WIDTH/8, one bit per element of this beat, LSB = element 0).
  - When in_vm=0, element i with in_v0[i]=0 produces mask bit 1 (mask-agnostic ones). Element i with in_v0[i]=1 produces the compare result.
  - When in_vm=1, in_v0 is ignored.
- When undefined: the ports are absent and every element produces its compare result.

Test Plan:
- Reset, then idle → out_valid=0, out_vec=0, out_be=0, in_ready=1.
- SEW=8, opSel=0: 8 beats with in_vec0==in_vec1 on all bytes, in_last on beat 8 → single word out_vec=64'hFFFF_FFFF_FFFF_FFFF, out_be=8'hFF, out_addr = first-beat address, out_valid 2 cycles after beat 8.
- SEW=64, opSel=3, in_vec0=64'hFFFF_FFFF_FFFF_FFFF (-1), in_vec1=1, single beat with last → out_vec=1, out_be=8'h01. Same operands with opSel=2 (ltu) → out_vec=0.
- SEW=32, opSel=6, 3 beats {5,2}>{1,7} each, last on beat 3 → out_vec=6'b010101, out_be=8'h01, upper bits 0.
- Backpressure: out_ready=0 for 5 cycles while words are pending → in_ready=0, out_* stable. Then out_ready=1 → back-to-back words, no loss or duplication.
- rst pulsed after 3 of 8 SEW=8 beats → no output. A following fresh 8-beat op emits a full word starting at bit 0.
